// File: rtl/rec_frame_pkg.sv
// rec_frame_pkg: shared constants, FSM encodings and descriptor layout
// for the store-and-forward receive frame buffer.
package rec_frame_pkg;

   localparam int BUF_AW     = 12;
   localparam int MAX_LEN    = 2047;
   localparam int MIN_LEN    = 64;
   localparam int DESC_DEPTH = 8;
   localparam int DESC_W     = 13;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DROP  = 2'd2
   } wr_state_t;

   typedef enum logic [1:0] {
      RIDLE = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2
   } rd_state_t;

   // What the write datapath does with the current input byte
   typedef enum logic [2:0] {
      ACT_NONE   = 3'd0,
      ACT_START  = 3'd1,
      ACT_ADV    = 3'd2,
      ACT_COMMIT = 3'd3,
      ACT_REWIND = 3'd4
   } wr_act_t;

   typedef struct packed {
      logic [11:0] len;
      logic        hi_pri;
   } desc_t;

   // Saturating add of a small increment to a 16-bit counter
   function automatic logic [15:0] sat_add(
      input logic [15:0] a,
      input logic [1:0]  b
   );
      logic [16:0] s;
      s = {1'b0, a} + {15'd0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

endpackage

// File: rtl/rec_desc_fifo.sv
// rec_desc_fifo: small descriptor FIFO with fall-through read data.
// A push while full is accepted only if a pop frees a slot that cycle.
module rec_desc_fifo
   import rec_frame_pkg::*;
#(
   parameter int W     = DESC_W,
   parameter int DEPTH = DESC_DEPTH
)
(
   input  logic         clk_sys,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign pop_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Descriptor storage
   always_ff @(posedge clk_sys) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/rec_frame_buffer.sv
// rec_frame_buffer: store-and-forward receive buffer. Whole frames land
// in a circular byte RAM; only committed frames stream to transmit.
module rec_frame_buffer
   import rec_frame_pkg::*;
(
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        in_valid,
   input  logic        in_sop,
   input  logic        in_eop,
   input  logic        in_err,
   input  logic        in_hi_pri,
   input  logic [7:0]  in_data,
   input  logic        m_discard_en,
   output logic [7:0]  f_data,
   output logic [23:0] f_ctrl,
   output logic        f_rec_data_valid,
   output logic        f_rec_frame_valid,
   output logic        f_hi_priority,
   output logic [15:0] drop_cnt,
   output logic [15:0] discard_cnt,
   output logic [15:0] frames_out
);

   typedef logic [BUF_AW-1:0] ptr_t;

   // A new frame needs room for the worst case before it is accepted
   localparam ptr_t SPACE_NEED = ptr_t'(MAX_LEN + 1);
   localparam ptr_t ONE        = ptr_t'(1);

   logic [7:0] mem [2**BUF_AW];
   logic [7:0] ram_q;

   wr_state_t  wr_state;
   wr_state_t  wr_next;
   wr_act_t    wr_act;
   ptr_t       wr_ptr;
   ptr_t       wr_base;
   ptr_t       wr_cnt;
   ptr_t       cnt_next;
   ptr_t       used;
   ptr_t       ram_wa;
   logic       wr_pri;
   logic       can_start;
   logic       bad_frame;
   logic       ram_we;
   logic [1:0] drop_inc;

   rd_state_t  rd_state;
   rd_state_t  rd_next;
   ptr_t       rd_ptr;
   ptr_t       rd_base;
   ptr_t       rd_len;
   ptr_t       rd_cnt;
   ptr_t       ram_ra;
   logic       rd_pri;
   logic       rd_last;
   logic       ram_re;
   logic       pop;
   logic       send;

   logic       fifo_full;
   logic       fifo_empty;
   desc_t      push_desc;
   desc_t      pop_desc;

   logic [15:0] drop_q;
   logic [15:0] discard_q;
   logic [15:0] frames_q;

   // Occupancy counts every committed byte not yet fully sent
   assign used      = wr_base - rd_base;
   assign can_start = (used <= SPACE_NEED) && !fifo_full;
   assign cnt_next  = wr_cnt + ONE;
   assign bad_frame = (cnt_next > ptr_t'(MAX_LEN))
                   || (in_eop && (in_err
                   || (cnt_next < ptr_t'(MIN_LEN))));

   assign push_desc = '{len: cnt_next, hi_pri: wr_pri};
   assign ram_we    = (wr_act == ACT_START)
                   || (wr_act == ACT_ADV)
                   || (wr_act == ACT_COMMIT);
   assign ram_wa    = (wr_act == ACT_START) ? wr_base : wr_ptr;

   rec_desc_fifo #(
      .W     (DESC_W),
      .DEPTH (DESC_DEPTH)
   ) u_desc_fifo (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .push      (wr_act == ACT_COMMIT),
      .push_data (push_desc),
      .pop       (pop),
      .pop_data  (pop_desc),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Write FSM state register
   always_ff @(posedge clk_sys) begin
      if (reset) wr_state <= IDLE;
      else       wr_state <= wr_next;
   end

   // Write FSM next state
   always_comb begin
      wr_next = wr_state;
      unique case (wr_state)
         IDLE: begin
            if (in_valid && in_sop && !in_eop)
               wr_next = can_start ? WRITE : DROP;
         end
         WRITE: begin
            if (in_valid) begin
               if (in_sop)
                  wr_next = in_eop ? IDLE : WRITE;
               else if (in_eop)
                  wr_next = IDLE;
               else if (cnt_next > ptr_t'(MAX_LEN))
                  wr_next = DROP;
            end
         end
         DROP: begin
            if (in_valid && in_eop) wr_next = IDLE;
         end
         default: wr_next = IDLE;
      endcase
   end

   // Write FSM outputs: datapath action and drop increments
   always_comb begin
      wr_act   = ACT_NONE;
      drop_inc = 2'd0;
      unique case (wr_state)
         IDLE: begin
            if (in_valid && in_sop) begin
               if (in_eop || !can_start) drop_inc = 2'd1;
               else                      wr_act   = ACT_START;
            end
         end
         WRITE: begin
            if (in_valid) begin
               if (in_sop && in_eop) begin
                  wr_act   = ACT_REWIND;
                  drop_inc = 2'd2;
               end else if (in_sop) begin
                  wr_act   = ACT_START;
                  drop_inc = 2'd1;
               end else if (bad_frame) begin
                  wr_act   = ACT_REWIND;
                  drop_inc = 2'd1;
               end else if (in_eop) begin
                  wr_act   = ACT_COMMIT;
               end else begin
                  wr_act   = ACT_ADV;
               end
            end
         end
         default: ;
      endcase
   end

   // Write pointers: the base only moves when a frame commits
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr  <= '0;
         wr_base <= '0;
         wr_cnt  <= '0;
         wr_pri  <= 1'b0;
      end else begin
         unique case (wr_act)
            ACT_START: begin
               wr_ptr <= wr_base + ONE;
               wr_cnt <= ONE;
               wr_pri <= in_hi_pri;
            end
            ACT_ADV: begin
               wr_ptr <= wr_ptr + ONE;
               wr_cnt <= cnt_next;
            end
            ACT_COMMIT: begin
               wr_ptr  <= wr_ptr + ONE;
               wr_base <= wr_ptr + ONE;
               wr_cnt  <= '0;
            end
            ACT_REWIND: begin
               wr_ptr <= wr_base;
               wr_cnt <= '0;
            end
            default: ;
         endcase
      end
   end

   // Byte RAM write port
   always_ff @(posedge clk_sys) begin
      if (ram_we) mem[ram_wa] <= in_data;
   end

   // Byte RAM read port; output holds while no read is issued
   always_ff @(posedge clk_sys) begin
      if (ram_re) ram_q <= mem[ram_ra];
   end

   assign send    = (rd_state == SEND);
   assign rd_last = (rd_cnt == rd_len - ONE);
   assign pop     = (rd_state == RIDLE) && !fifo_empty;
   assign ram_re  = pop || send;
   assign ram_ra  = (rd_state == RIDLE) ? rd_base : rd_ptr;

   // Read FSM state register
   always_ff @(posedge clk_sys) begin
      if (reset) rd_state <= RIDLE;
      else       rd_state <= rd_next;
   end

   // Read FSM next state
   always_comb begin
      rd_next = rd_state;
      unique case (rd_state)
         RIDLE:   if (!fifo_empty) rd_next = FETCH;
         FETCH:   rd_next = SEND;
         SEND:    if (rd_last) rd_next = RIDLE;
         default: rd_next = RIDLE;
      endcase
   end

   // Read FSM outputs, forced quiet while reset is held
   always_comb begin
      f_rec_data_valid  = 1'b0;
      f_rec_frame_valid = 1'b0;
      f_hi_priority     = 1'b0;
      f_data            = 8'd0;
      f_ctrl            = 24'd0;
      if (!reset && send) begin
         f_rec_data_valid = 1'b1;
         f_hi_priority    = rd_pri;
         f_data           = ram_q;
         if (rd_cnt == '0) begin
            f_rec_frame_valid = 1'b1;
            f_ctrl            = {rd_len, rd_len};
         end
      end
   end

   // Read pointers: the base is released after the last byte
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         rd_base  <= '0;
         rd_ptr   <= '0;
         rd_len   <= '0;
         rd_cnt   <= '0;
         rd_pri   <= 1'b0;
         frames_q <= '0;
      end else if (pop) begin
         rd_len <= pop_desc.len;
         rd_pri <= pop_desc.hi_pri;
         rd_ptr <= rd_base + ONE;
         rd_cnt <= '0;
      end else if (send) begin
         rd_ptr <= rd_ptr + ONE;
         rd_cnt <= rd_cnt + ONE;
         if (rd_last) begin
            rd_base  <= rd_base + rd_len;
            frames_q <= frames_q + 16'd1;
         end
      end
   end

   // Saturating drop and discard statistics
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         drop_q    <= '0;
         discard_q <= '0;
      end else begin
         drop_q    <= sat_add(drop_q, drop_inc);
         discard_q <= sat_add(discard_q, {1'b0, m_discard_en});
      end
   end

   assign drop_cnt    = reset ? 16'd0 : drop_q;
   assign discard_cnt = reset ? 16'd0 : discard_q;
   assign frames_out  = reset ? 16'd0 : frames_q;

endmodule

// File: tb/tb_rec_frame_buffer.sv
// tb_rec_frame_buffer: scenario tasks drive frames, push expected
// frames to a queue, and a collector checks the output stream.
module tb_rec_frame_buffer;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_sop = 1'b0;
   logic        in_eop = 1'b0;
   logic        in_err = 1'b0;
   logic        in_hi_pri = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        m_discard_en = 1'b0;
   logic [7:0]  f_data;
   logic [23:0] f_ctrl;
   logic        f_rec_data_valid;
   logic        f_rec_frame_valid;
   logic        f_hi_priority;
   logic [15:0] drop_cnt;
   logic [15:0] discard_cnt;
   logic [15:0] frames_out;

   int n_checks = 0;
   int n_fail = 0;
   int unsigned cyc = 0;

   typedef struct {
      int          len;
      bit          pri;
      int          seed;
      int unsigned eop_cyc;
      bit          chk_lat;
   } exp_t;

   exp_t exp_q[$];

   rec_frame_buffer dut (
      .clk_sys           (clk_sys),
      .reset             (reset),
      .in_valid          (in_valid),
      .in_sop            (in_sop),
      .in_eop            (in_eop),
      .in_err            (in_err),
      .in_hi_pri         (in_hi_pri),
      .in_data           (in_data),
      .m_discard_en      (m_discard_en),
      .f_data            (f_data),
      .f_ctrl            (f_ctrl),
      .f_rec_data_valid  (f_rec_data_valid),
      .f_rec_frame_valid (f_rec_frame_valid),
      .f_hi_priority     (f_hi_priority),
      .drop_cnt          (drop_cnt),
      .discard_cnt       (discard_cnt),
      .frames_out        (frames_out)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] exp_byte(
      input int seed, input int idx, input int len);
      if (seed == 0)
         return (idx < 4 || idx >= len - 4) ? 8'hFF : 8'h00;
      return 8'(seed * 29 + idx * 7 + idx / 251);
   endfunction

   task automatic drive_idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_sys);
         in_valid  = 1'b0;
         in_sop    = 1'b0;
         in_eop    = 1'b0;
         in_err    = 1'b0;
         in_hi_pri = 1'b0;
         in_data   = 8'd0;
      end
   endtask

   task automatic drive_frame(
      input int len, input bit pri, input bit err,
      input int seed, input bit noeop,
      input bit fwd, input bit chk_lat);
      exp_t e;
      for (int i = 0; i < len; i++) begin
         @(negedge clk_sys);
         in_valid  = 1'b1;
         in_sop    = (i == 0);
         in_eop    = (i == len - 1) && !noeop;
         in_err    = err && in_eop;
         in_hi_pri = pri && (i == 0);
         in_data   = exp_byte(seed, i, len);
      end
      if (fwd) begin
         e.len     = len;
         e.pri     = pri;
         e.seed    = seed;
         e.eop_cyc = cyc;
         e.chk_lat = chk_lat;
         exp_q.push_back(e);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk_sys);
      reset        = 1'b1;
      in_valid     = 1'b0;
      in_sop       = 1'b0;
      in_eop       = 1'b0;
      m_discard_en = 1'b0;
      repeat (2) @(negedge clk_sys);
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic collect(input int nfr, input int budget);
      exp_t cur;
      int got, idx, waited;
      bit busy, gap;
      logic [7:0] eb;
      got = 0; idx = 0; waited = 0; busy = 0; gap = 0;
      cur = '{len: 1, pri: 0, seed: 0, eop_cyc: 0, chk_lat: 0};
      while (got < nfr && waited < budget) begin
         @(negedge clk_sys);
         waited++;
         if (gap) begin
            n_checks++;
            if (f_rec_data_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL frame_gap: valid=%b required 0",
                        f_rec_data_valid);
            end
            gap = 0;
         end
         if (f_rec_data_valid === 1'b1) begin
            if (!busy) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_frame: ctrl=%h none expected",
                           f_ctrl);
                  cur = '{len: 1, pri: 0, seed: 0,
                          eop_cyc: 0, chk_lat: 0};
               end else begin
                  cur = exp_q.pop_front();
               end
               busy = 1; idx = 0;
               n_checks++;
               if (f_rec_frame_valid !== 1'b1 ||
                   f_ctrl !== {12'(cur.len), 12'(cur.len)}) begin
                  n_fail++;
                  $display("FAIL first_byte: fv=%b ctrl=%h required 1 %h",
                           f_rec_frame_valid, f_ctrl,
                           {12'(cur.len), 12'(cur.len)});
               end
               if (cur.chk_lat) begin
                  n_checks++;
                  if (cyc - cur.eop_cyc != 3) begin
                     n_fail++;
                     $display("FAIL latency: %0d cycles required 3",
                              cyc - cur.eop_cyc);
                  end
               end
            end else begin
               n_checks++;
               if (f_rec_frame_valid !== 1'b0 || f_ctrl !== 24'd0) begin
                  n_fail++;
                  $display("FAIL mid_ctrl: fv=%b ctrl=%h required 0 0",
                           f_rec_frame_valid, f_ctrl);
               end
            end
            eb = exp_byte(cur.seed, idx, cur.len);
            n_checks++;
            if (f_data !== eb || f_hi_priority !== cur.pri) begin
               n_fail++;
               $display("FAIL data[%0d]: got %h pri %b required %h pri %b",
                        idx, f_data, f_hi_priority, eb, cur.pri);
            end
            idx++;
            if (idx >= cur.len) begin
               busy = 0; got++; gap = 1;
            end
         end else begin
            n_checks++;
            if (busy || f_rec_data_valid !== 1'b0 || f_data !== 8'd0 ||
                f_rec_frame_valid !== 1'b0 || f_ctrl !== 24'd0) begin
               n_fail++;
               $display("FAIL idle_out: busy=%b v=%b d=%h fv=%b ctrl=%h required 0",
                        busy, f_rec_data_valid, f_data,
                        f_rec_frame_valid, f_ctrl);
               if (busy) begin
                  busy = 0; got++;
               end
            end
         end
      end
      n_checks++;
      if (got < nfr) begin
         n_fail++;
         $display("FAIL collect_timeout: got %0d frames required %0d",
                  got, nfr);
      end
      if (gap) begin
         @(negedge clk_sys);
         n_checks++;
         if (f_rec_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_gap: valid=%b required 0",
                     f_rec_data_valid);
         end
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL missing_frames: %0d left required 0",
                  exp_q.size());
      end
   endtask

   task automatic check_stats(
      input string name, input int drops, input int frames);
      n_checks++;
      if (drop_cnt !== 16'(drops) || frames_out !== 16'(frames)) begin
         n_fail++;
         $display("FAIL %s: drop=%0d frames=%0d required %0d %0d",
                  name, drop_cnt, frames_out, drops, frames);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk_sys);
      n_checks++;
      if (f_rec_data_valid !== 1'b0 || f_data !== 8'd0 ||
          f_ctrl !== 24'd0 || f_rec_frame_valid !== 1'b0 ||
          f_hi_priority !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_out: v=%b d=%h ctrl=%h required 0",
                  f_rec_data_valid, f_data, f_ctrl);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk_sys);
      n_checks++;
      if (f_rec_data_valid !== 1'b0 || drop_cnt !== 16'd0 ||
          discard_cnt !== 16'd0 || frames_out !== 16'd0) begin
         n_fail++;
         $display("FAIL after_reset: v=%b drop=%h disc=%h fr=%h required 0",
                  f_rec_data_valid, drop_cnt, discard_cnt, frames_out);
      end
   endtask

   task automatic test_single();
      apply_reset();
      fork
         begin
            drive_frame(512, 0, 0, 0, 0, 1, 1);
            drive_idle(1);
         end
         collect(1, 2000);
      join
      check_stats("single_stats", 0, 1);
   endtask

   task automatic test_back_to_back();
      apply_reset();
      fork
         begin
            for (int i = 0; i < 64; i++)
               drive_frame(512, i[0], 0, i + 1, 0, 1, 0);
            drive_idle(1);
         end
         collect(64, 64 * 600);
      join
      check_stats("b2b_stats", 0, 64);
   endtask

   task automatic test_lengths();
      apply_reset();
      fork
         begin
            drive_frame(63,   0, 0, 101, 0, 0, 0);
            drive_frame(64,   1, 0, 102, 0, 1, 0);
            drive_frame(2047, 0, 0, 103, 0, 1, 0);
            drive_frame(2048, 1, 0, 104, 0, 0, 0);
            drive_frame(100,  0, 1, 105, 0, 0, 0);
            drive_frame(1,    0, 0, 106, 0, 0, 0);
            drive_frame(50,   0, 0, 107, 1, 0, 0);
            drive_frame(70,   1, 0, 108, 0, 1, 0);
            drive_idle(1);
         end
         collect(3, 12000);
      join
      check_stats("length_stats", 5, 3);
   endtask

   task automatic test_overflow();
      apply_reset();
      fork
         begin
            drive_frame(1000, 1, 0, 200, 0, 1, 0);
            for (int i = 0; i < 10; i++)
               drive_frame(64, 0, 0, 201 + i, 0, i < 8, 0);
            drive_idle(1);
         end
         collect(9, 4000);
      join
      check_stats("overflow_stats", 2, 9);
   endtask

   task automatic test_reset_mid();
      int w;
      apply_reset();
      drive_frame(100, 0, 0, 300, 1, 0, 0);
      @(negedge clk_sys);
      reset    = 1'b1;
      in_valid = 1'b0;
      in_sop   = 1'b0;
      @(negedge clk_sys);
      n_checks++;
      if (f_rec_data_valid !== 1'b0 || f_data !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_write: v=%b d=%h required 0",
                  f_rec_data_valid, f_data);
      end
      reset = 1'b0;
      drive_frame(300, 1, 0, 301, 0, 0, 0);
      drive_idle(1);
      w = 0;
      while (f_rec_data_valid !== 1'b1 && w < 50) begin
         @(negedge clk_sys);
         w++;
      end
      n_checks++;
      if (f_rec_data_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL send_start: v=%b required 1", f_rec_data_valid);
      end
      repeat (10) @(negedge clk_sys);
      reset = 1'b1;
      @(negedge clk_sys);
      n_checks++;
      if (f_rec_data_valid !== 1'b0 || f_data !== 8'd0 ||
          f_ctrl !== 24'd0 || f_hi_priority !== 1'b0 ||
          frames_out !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_send: v=%b d=%h pri=%b fr=%h required 0",
                  f_rec_data_valid, f_data, f_hi_priority, frames_out);
      end
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk_sys);
      check_stats("post_reset_stats", 0, 0);
      fork
         begin
            drive_frame(80, 0, 0, 302, 0, 1, 1);
            drive_idle(1);
         end
         collect(1, 500);
      join
      check_stats("clean_stats", 0, 1);
   endtask

   task automatic test_discard();
      apply_reset();
      @(negedge clk_sys);
      m_discard_en = 1'b1;
      @(negedge clk_sys);
      m_discard_en = 1'b0;
      n_checks++;
      if (discard_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL discard_one: got %0d required 1", discard_cnt);
      end
      for (int i = 0; i < 2; i++) begin
         repeat (2) @(negedge clk_sys);
         m_discard_en = 1'b1;
         @(negedge clk_sys);
         m_discard_en = 1'b0;
      end
      repeat (2) @(negedge clk_sys);
      n_checks++;
      if (discard_cnt !== 16'd3) begin
         n_fail++;
         $display("FAIL discard_three: got %0d required 3", discard_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_lengths();
      test_overflow();
      test_reset_mid();
      test_discard();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
